osc_tick_sched: RTL and testbench



---
 rtl/osc_pkg.sv | 18 +
 rtl/osc_tick_div.sv | 81 ++++++++
 rtl/osc_tick_sched.sv | 112 +++++++++++
 tb/tb_osc_tick_sched.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/osc_pkg.sv
// Shared types and defaults for the oscillator tick scheduler.
package osc_pkg;

  typedef enum logic [1:0] {
    SYNC,
    SETTLE,
    RUN
  } osc_state_e;

  localparam int N_CH_DEF       = 4;
  localparam int DIV_W_DEF      = 16;
  localparam int SETTLE_CYC_DEF = 1024;

  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/osc_tick_div.sv
// One tick channel: down-counter with active and shadow divider.
module osc_tick_div
  import osc_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic             wr_en,
  input  logic [DIV_W-1:0] wr_div,
  output logic             tick
);

  logic             en_q, en_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] shd_q, shd_d;

  always_comb begin
    en_d   = en_q;
    pend_d = pend_q;
    cnt_d  = cnt_q;
    div_d  = div_q;
    shd_d  = shd_q;
    tick_d = 1'b0;

    if (en_q) begin
      if (cnt_q == '0) begin
        tick_d = 1'b1;
        cnt_d  = pend_q ? shd_q : div_q;
        div_d  = pend_q ? shd_q : div_q;
        pend_d = 1'b0;
      end else begin
        cnt_d = cnt_q - DIV_W'(1);
      end
    end

    // a write landing on a reload edge is queued for the next reload
    if (wr) begin
      if (!en_q) begin
        en_d   = wr_en;
        div_d  = wr_div;
        cnt_d  = wr_div;
        pend_d = 1'b0;
      end else if (wr_en) begin
        shd_d  = wr_div;
        pend_d = 1'b1;
      end else begin
        en_d   = 1'b0;
        pend_d = 1'b0;
        cnt_d  = cnt_q;
        div_d  = div_q;
        tick_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      pend_q <= 1'b0;
      tick_q <= 1'b0;
      cnt_q  <= '0;
      div_q  <= '0;
      shd_q  <= '0;
    end else begin
      en_q   <= en_d;
      pend_q <= pend_d;
      tick_q <= tick_d;
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      shd_q  <= shd_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/osc_tick_sched.sv
// Oscillator start-up sequencer and per-channel tick scheduler.
module osc_tick_sched
  import osc_pkg::*;
#(
  parameter  int N_CH       = N_CH_DEF,
  parameter  int DIV_W      = DIV_W_DEF,
  parameter  int SETTLE_CYC = SETTLE_CYC_DEF,
  localparam int CH_W       = ch_w(N_CH)
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_en,
  output logic             cfg_err,
  output logic             rst_out_n,
  output logic [N_CH-1:0]  tick
);

  localparam int SET_W =
    (SETTLE_CYC <= 1) ? 1 : $clog2(SETTLE_CYC);
  localparam logic [SET_W-1:0] SET_LAST =
    SET_W'(SETTLE_CYC - 1);
  localparam logic [CH_W:0] N_CH_V =
    (CH_W + 1)'(N_CH);

  osc_state_e       state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [SET_W-1:0] set_cnt_q, set_cnt_d;
  logic             rst_out_q, rst_out_d;
  logic             err_hit_q, err_hit_d;
  logic             err_q, err_d;
  logic             accept;
  logic             ch_bad;

  assign cfg_ready = (state_q == RUN);
  assign accept    = cfg_valid && cfg_ready;
  assign ch_bad    = {1'b0, cfg_ch} >= N_CH_V;

  always_comb begin
    sync_d    = {sync_q[0], 1'b1};
    state_d   = state_q;
    set_cnt_d = set_cnt_q;

    unique case (state_q)
      // the edge leaving SYNC is the first settle cycle
      SYNC: begin
        if (sync_q[1]) begin
          state_d   = (SETTLE_CYC <= 1) ? RUN : SETTLE;
          set_cnt_d = SET_W'(1);
        end
      end
      SETTLE: begin
        if (set_cnt_q == SET_LAST) begin
          state_d = RUN;
        end else begin
          set_cnt_d = set_cnt_q + SET_W'(1);
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = SYNC;
      end
    endcase

    rst_out_d = (state_d == RUN);
    err_hit_d = accept && ch_bad;
    err_d     = err_hit_q;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= SYNC;
      sync_q    <= '0;
      set_cnt_q <= '0;
      rst_out_q <= 1'b0;
      err_hit_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      set_cnt_q <= set_cnt_d;
      rst_out_q <= rst_out_d;
      err_hit_q <= err_hit_d;
      err_q     <= err_d;
    end
  end

  assign rst_out_n = rst_out_q;
  assign cfg_err   = err_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic wr;
    assign wr = accept && (cfg_ch == CH_W'(i));

    osc_tick_div #(
      .DIV_W (DIV_W)
    ) u_div (
      .clk    (sys_clk),
      .rst_n  (sys_rst_n),
      .wr     (wr),
      .wr_en  (cfg_en),
      .wr_div (cfg_div),
      .tick   (tick[i])
    );
  end

endmodule

// File: tb/tb_osc_tick_sched.sv
// Scoreboard bench for osc_tick_sched with a period-based reference.
module tb_osc_tick_sched;

  localparam int NC = 3;
  localparam int DW = 8;
  localparam int SC = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [1:0]    cfg_ch;
  logic [DW-1:0] cfg_div;
  logic          cfg_en;
  logic          cfg_err;
  logic          rst_out_n;
  logic [NC-1:0] tick;

  always #5 clk = ~clk;

  osc_tick_sched #(
    .N_CH       (NC),
    .DIV_W      (DW),
    .SETTLE_CYC (SC)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_en    (cfg_en),
    .cfg_err   (cfg_err),
    .rst_out_n (rst_out_n),
    .tick      (tick)
  );

  typedef struct packed {
    logic          rst;
    logic          rdy;
    logic          err;
    logic [NC-1:0] tick;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  int   n;
  bit   err_s1;
  bit   m_en[NC];
  bit   m_pend[NC];
  int   m_next[NC];
  int   m_per[NC];
  int   m_pdiv[NC];

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s n=%0d got %0h want %0h",
               tag, n, act, exp);
    end
  endtask

  task automatic model_reset();
    n      = 0;
    err_s1 = 1'b0;
    for (int i = 0; i < NC; i++) begin
      m_en[i]   = 1'b0;
      m_pend[i] = 1'b0;
    end
  endtask

  // expected outputs after this rising edge
  task automatic model_step();
    exp_t e;
    bit   rdy_b, acc, wr;
    e = '0;
    if (!rst_n) begin
      model_reset();
      sb_q.push_back(e);
      return;
    end
    rdy_b  = (n >= 2 + SC);
    n++;
    acc    = cfg_valid && rdy_b;
    e.err  = err_s1;
    err_s1 = acc && (int'(cfg_ch) >= NC);
    for (int i = 0; i < NC; i++) begin
      wr = acc && (int'(cfg_ch) == i);
      if (wr && m_en[i] && !cfg_en) begin
        m_en[i]   = 1'b0;
        m_pend[i] = 1'b0;
      end else begin
        if (m_en[i] && n == m_next[i]) begin
          e.tick[i] = 1'b1;
          if (m_pend[i]) m_per[i] = m_pdiv[i] + 1;
          m_pend[i] = 1'b0;
          m_next[i] = n + m_per[i];
        end
        if (wr && !m_en[i]) begin
          m_en[i] = cfg_en;
          if (cfg_en) begin
            m_per[i]  = int'(cfg_div) + 1;
            m_next[i] = n + m_per[i];
          end
        end else if (wr) begin
          m_pdiv[i] = int'(cfg_div);
          m_pend[i] = 1'b1;
        end
      end
    end
    e.rst = (n >= 2 + SC);
    e.rdy = e.rst;
    sb_q.push_back(e);
  endtask

  task automatic cyc();
    exp_t e;
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("sb_depth", sb_q.size(), 1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("tick", {29'd0, tick}, {29'd0, e.tick});
      chk("ctl", {29'd0, rst_out_n, cfg_ready, cfg_err},
          {29'd0, e.rst, e.rdy, e.err});
    end
  endtask

  task automatic run(input int k);
    repeat (k) cyc();
  endtask

  task automatic wr_cfg(input int ch, input bit en,
                        input int div);
    cfg_valid = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_en    = en;
    cfg_div   = DW'(div);
    cyc();
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
    cfg_en    = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_vals",
        {26'd0, rst_out_n, cfg_ready, cfg_err, tick}, 32'd0);

    rst_n = 1'b1;
    // writes offered during start-up must be ignored
    cfg_valid = 1'b1;
    cfg_ch    = 2'd0;
    cfg_en    = 1'b1;
    cfg_div   = 8'd0;
    run(10);
    cfg_valid = 1'b0;
    run(12);

    wr_cfg(0, 1'b1, 3);
    run(12);

    wr_cfg(1, 1'b1, 9);
    run(3);
    wr_cfg(1, 1'b1, 2);
    run(25);

    wr_cfg(2, 1'b1, 0);
    run(5);
    wr_cfg(2, 1'b0, 0);
    run(4);
    wr_cfg(2, 1'b1, 1);
    run(8);

    wr_cfg(3, 1'b1, 5);
    run(6);

    wr_cfg(0, 1'b1, 7);
    wr_cfg(0, 1'b1, 1);
    run(14);

    rst_n = 1'b0;
    #1;
    chk("async_tick", {29'd0, tick}, 32'd0);
    chk("async_rst", {31'd0, rst_out_n}, 32'd0);
    chk("async_rdy", {31'd0, cfg_ready}, 32'd0);
    model_reset();
    run(3);
    rst_n = 1'b1;
    run(25);
    run(15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
